imm_pack: RTL and testbench
===========================

Name: imm_pack

Overview:
- Inverse of the datapath immediate extender. Takes a 32-bit constant and produces the narrowest immediate-field encoding: imm_1 (19b), imm_2 (23b) and imm_ctrl (2b), such that the core's extender reconstructs the value exactly.
- Constants that do not fit any single encoding are split into a two-beat hi/lo sequence.
- Sits between the assembler/constant-generation front end and the instruction-word builder.
- Valid/ready handshakes are used on both sides.

Parameters:
- ALLOW_SPLIT, 1: 1 = unfit constants emit two beats; 0 = unfit constants emit one error beat.
- LO_BITS, 16: width of the low half in split mode; legal range 13..18.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  constant offered
- in_ready  out  1  block can accept
- in_value  in  32  constant to encode
- out_valid  out  1  encoded beat available
- out_ready  in  1  downstream accepts beat
- imm_1  out  19  field for ctrl 00/01
- imm_2  out  23  field for ctrl 10
- imm_ctrl  out  2  00 zero-ext19, 01 sign-ext19, 10 sign-ext23, 11 none/error
- out_hi  out  1  beat is the upper half of a split
- out_last  out  1  final beat for this constant
- out_err  out  1  constant unencodable (ALLOW_SPLIT=0 only)

Behaviour:
- Classification uses fixed priority, first match wins:
  - ZX19 if in_value[31:19]==0.
  - SX19 if in_value[31:18] is all-equal.
  - SX23 if in_value[31:22] is all-equal.
  - Otherwise SPLIT.
- Field drive rules:
  - ZX19 and SX19 drive imm_1 = value[18:0].
  - SX23 drives imm_2 = value[22:0].
  - Any unused field is driven to 0.
- FSM states: IDLE, ONE, HI, LO. A transfer occurs only on valid&&ready at a rising edge.
- IDLE:
  - in_ready=1.
  - On accept, register the value and class, then go to HI if class is SPLIT and ALLOW_SPLIT=1, else ONE.
  - Latency is 1 cycle: out_valid rises the cycle after accept.
- ONE:
  - Emit one beat with out_last=1 and out_hi=0.
  - If ALLOW_SPLIT=0 and class is SPLIT: imm_ctrl=11, fields 0, out_err=1.
- HI:
  - imm_ctrl=00, imm_1 = zero-extended value[31:LO_BITS], out_hi=1, out_last=0.
  - On out_ready go to LO.
- LO:
  - imm_ctrl=00, imm_1 = zero-extended value[LO_BITS-1:0], out_hi=0, out_last=1.
- Back-to-back: in_ready = (state==IDLE) || (out_valid && out_ready && out_last).
  - A new accept in the same cycle the last beat retires loads directly into ONE/HI with no bubble.
  - Otherwise the FSM returns to IDLE.
- Backpressure:
  - While out_valid && !out_ready, all out_* signals hold stable.
  - in_ready stays low (except the last-beat case above).
- Reset:
  - rst=1 in any state: next edge state=IDLE, out_valid=0, in_ready=1.
  - imm_1, imm_2, out_hi, out_last and out_err are 0; imm_ctrl=11.
  - The registered value is cleared, and a split in progress is dropped.
- in_value is sampled only on accept; changes while not accepted are ignored.

Optional Feature:
- Macro: IMM_PACK_STATS_EN.
- Defined:
  - Adds output split_count[15:0]: a saturating counter incremented on each accepted SPLIT-class constant (including error beats when ALLOW_SPLIT=0).
  - It holds at 0xFFFF when saturated and is cleared by rst.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Package imm_pkg holds:
  - Enum imm_ctrl_t: IMM_ZX19=2'b00, IMM_SX19=2'b01, IMM_SX23=2'b10, IMM_NONE=2'b11.
  - Constants IMM1_W=19, IMM2_W=23.
  - The FSM state enum.
  - This package is also imported by the extender's users.
- Sub-module imm_classify: purely combinational, value to class. It is reused by the assembler-side checker.

Test Plan:
- 0x0004_0000 -> one beat: ctrl 00, imm_1=0x40000, out_last=1, out_hi=0.
- 0xFFFF_FFFB -> one beat: ctrl 01, imm_1=0x7FFFB.
- 0xFFF0_0000 -> one beat: ctrl 10, imm_2=0x700000, imm_1=0.
- 0x1234_5678 with LO_BITS=16:
  - Beat 1: ctrl 00, imm_1=0x01234, out_hi=1, out_last=0.
  - Beat 2: imm_1=0x05678, out_last=1.
  - The next value is accepted on the same edge as beat 2 (no bubble).
- Back-to-back beats with out_ready held 0 for 3 cycles during HI:
  - Outputs stay stable and in_ready=0.
  - With ALLOW_SPLIT=0, 0x1234_5678 -> ctrl 11, out_err=1, out_last=1.
- rst asserted in LO -> next cycle out_valid=0, in_ready=1, imm_ctrl=11; a following 0x5 yields ctrl 00, imm_1=0x5.

Source files
------------

// File: rtl/imm_pkg.sv
// imm_pkg: shared types and constants for the immediate extender and its
// inverse (imm_pack). Extender users import this package as well.
//   imm_ctrl_t  : encoding selector carried next to the immediate fields
//   imm_state_t : imm_pack beat-sequencer states
//   IMM1_W/IMM2_W: widths of the two immediate fields
package imm_pkg;

    localparam int VAL_W  = 32;
    localparam int IMM1_W = 19;
    localparam int IMM2_W = 23;

    typedef enum logic [1:0] {
        IMM_ZX19 = 2'b00,
        IMM_SX19 = 2'b01,
        IMM_SX23 = 2'b10,
        IMM_NONE = 2'b11
    } imm_ctrl_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ONE,
        ST_HI,
        ST_LO
    } imm_state_t;

endpackage

// File: rtl/imm_pack_if.sv
// imm_pack_if: constant-in / encoded-beat-out handshake bundle.
//   in_valid/in_ready/in_value : constant offered by the front end
//   out_valid/out_ready        : encoded beat handshake
//   imm_1/imm_2/imm_ctrl       : immediate fields and encoding selector
//   out_hi/out_last/out_err    : split-beat position and error flag
// master = front end + instruction builder side, slave = imm_pack.
interface imm_pack_if;
    import imm_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [VAL_W-1:0]     in_value;
    logic                 out_valid;
    logic                 out_ready;
    logic [IMM1_W-1:0]    imm_1;
    logic [IMM2_W-1:0]    imm_2;
    imm_ctrl_t            imm_ctrl;
    logic                 out_hi;
    logic                 out_last;
    logic                 out_err;

    modport master (
        output in_valid, in_value, out_ready,
        input  in_ready, out_valid, imm_1, imm_2, imm_ctrl, out_hi, out_last, out_err
    );

    modport slave (
        input  in_valid, in_value, out_ready,
        output in_ready, out_valid, imm_1, imm_2, imm_ctrl, out_hi, out_last, out_err
    );

endinterface

// File: rtl/imm_classify.sv
// imm_classify: combinational class of a 32-bit constant, first match wins:
// ZX19, SX19, SX23, else IMM_NONE (needs a split). Only bits [31:18]
// decide the class, so only those are taken.
//   val_top in  14  value[31:18]
//   cls     out 2   class as imm_ctrl_t
module imm_classify
    import imm_pkg::*;
(
    input  logic [VAL_W-1:IMM1_W-1] val_top,
    output imm_ctrl_t               cls
);

    logic zx19, sx19, sx23;

    assign zx19 = ~|val_top[VAL_W-1:IMM1_W];
    assign sx19 = (&val_top) | ~(|val_top);
    assign sx23 = (&val_top[VAL_W-1:IMM2_W-1]) | ~(|val_top[VAL_W-1:IMM2_W-1]);

    always_comb begin
        cls = IMM_NONE;
        if (zx19)      cls = IMM_ZX19;
        else if (sx19) cls = IMM_SX19;
        else if (sx23) cls = IMM_SX23;
    end

endmodule

// File: rtl/imm_pack.sv
// imm_pack: encodes a 32-bit constant into the narrowest immediate form
// (imm_1/imm_2/imm_ctrl). Constants that fit nothing become a hi/lo pair
// of zero-extended beats (ALLOW_SPLIT=1) or a single error beat (=0).
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : imm_pack_if.slave (input handshake, encoded beat out)
//   split_count (IMM_PACK_STATS_EN only): saturating count of accepted
//               constants that needed a split
// Optional feature macro: IMM_PACK_STATS_EN.
// Outputs are decoded from registered state only, so they hold under
// backpressure without extra output registers.
module imm_pack
    import imm_pkg::*;
#(
    parameter int unsigned ALLOW_SPLIT = 1,
    parameter int unsigned LO_BITS     = 16
) (
    input  logic          clk,
    input  logic          rst,
    imm_pack_if.slave     bus
`ifdef IMM_PACK_STATS_EN
    ,
    output logic [15:0]   split_count
`endif
);

    if (LO_BITS < 13 || LO_BITS > 18) begin : g_bad_lo_bits
        $error("imm_pack: LO_BITS must be 13..18");
    end

    localparam logic [VAL_W-1:0] LO_MASK = (VAL_W'(1) << LO_BITS) - VAL_W'(1);

    imm_state_t        state_q, state_d;
    logic [VAL_W-1:0]  val_q;
    imm_ctrl_t         cls_q, in_cls;
    logic              accept, retire;

    logic              out_valid, out_hi, out_last, out_err, in_ready;
    logic [IMM1_W-1:0] imm_1;
    logic [IMM2_W-1:0] imm_2;
    imm_ctrl_t         imm_ctrl;

    imm_classify u_cls (
        .val_top (bus.in_value[VAL_W-1:IMM1_W-1]),
        .cls     (in_cls)
    );

    always_comb begin
        state_d   = state_q;
        out_valid = 1'b0;
        out_hi    = 1'b0;
        out_last  = 1'b0;
        out_err   = 1'b0;
        imm_1     = '0;
        imm_2     = '0;
        imm_ctrl  = IMM_NONE;

        case (state_q)
            ST_ONE: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                imm_ctrl  = cls_q;
                case (cls_q)
                    IMM_ZX19, IMM_SX19: imm_1 = val_q[IMM1_W-1:0];
                    IMM_SX23:           imm_2 = val_q[IMM2_W-1:0];
                    default:            out_err = 1'b1; // only reachable with ALLOW_SPLIT=0
                endcase
            end
            ST_HI: begin
                out_valid = 1'b1;
                out_hi    = 1'b1;
                imm_ctrl  = IMM_ZX19;
                imm_1     = IMM1_W'(val_q >> LO_BITS);
            end
            ST_LO: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                imm_ctrl  = IMM_ZX19;
                imm_1     = IMM1_W'(val_q & LO_MASK);
            end
            default: ;
        endcase

        // Retiring the last beat frees the value register in the same cycle,
        // so the next constant loads with no bubble.
        retire   = out_valid && bus.out_ready;
        in_ready = (state_q == ST_IDLE) || (retire && out_last);
        accept   = bus.in_valid && in_ready;

        if (accept)
            state_d = (in_cls == IMM_NONE && ALLOW_SPLIT != 0) ? ST_HI : ST_ONE;
        else if (retire)
            state_d = (state_q == ST_HI) ? ST_LO : ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= '0;
            cls_q <= IMM_NONE;
        end else if (accept) begin
            val_q <= bus.in_value;
            cls_q <= in_cls;
        end
    end

`ifdef IMM_PACK_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)
            split_count <= '0;
        else if (accept && in_cls == IMM_NONE && split_count != 16'hFFFF)
            split_count <= split_count + 16'd1;
    end
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_hi    = out_hi;
    assign bus.out_last  = out_last;
    assign bus.out_err   = out_err;
    assign bus.imm_1     = imm_1;
    assign bus.imm_2     = imm_2;
    assign bus.imm_ctrl  = imm_ctrl;

endmodule

// File: tb/tb_imm_pack.sv
// tb_imm_pack: scoreboard bench for imm_pack. Two instances: dut_a
// (ALLOW_SPLIT=1, LO_BITS=16) and dut_b (ALLOW_SPLIT=0). Expected beats are
// pushed on accept from a range-based model; negedge monitors pop/compare.
module tb_imm_pack;
    import imm_pkg::*;

    localparam int LO = 16;

    typedef struct {
        imm_ctrl_t   ctrl;
        logic [18:0] imm1;
        logic [22:0] imm2;
        logic        hi;
        logic        last;
        logic        err;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imm_pack_if ia();
    imm_pack_if ib();

`ifdef IMM_PACK_STATS_EN
    logic [15:0] sc_a, sc_b;
`endif

    imm_pack #(.ALLOW_SPLIT(1), .LO_BITS(LO)) dut_a (
        .clk (clk), .rst (rst), .bus (ia.slave)
`ifdef IMM_PACK_STATS_EN
        , .split_count (sc_a)
`endif
    );

    imm_pack #(.ALLOW_SPLIT(0), .LO_BITS(LO)) dut_b (
        .clk (clk), .rst (rst), .bus (ib.slave)
`ifdef IMM_PACK_STATS_EN
        , .split_count (sc_b)
`endif
    );

    beat_t qa[$];
    beat_t qb[$];
    int checks = 0;
    int errors = 0;
    int exp_splits_a = 0;
    int exp_splits_b = 0;
    bit rdy_rand = 1'b0;
    bit stall_a = 1'b0;
    logic [46:0] snap_a;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: classify by numeric range of the constant.
    function automatic int model(input logic [31:0] v, input bit split_en,
                                 output beat_t b0, output beat_t b1);
        int sv;
        sv = $signed(v);
        b0.ctrl = IMM_NONE; b0.imm1 = '0; b0.imm2 = '0;
        b0.hi = 1'b0; b0.last = 1'b1; b0.err = 1'b0;
        b1 = b0;
        if (v < 32'h0008_0000) begin
            b0.ctrl = IMM_ZX19; b0.imm1 = v[18:0]; return 1;
        end
        if (sv >= -(2**18) && sv < 2**18) begin
            b0.ctrl = IMM_SX19; b0.imm1 = v[18:0]; return 1;
        end
        if (sv >= -(2**22) && sv < 2**22) begin
            b0.ctrl = IMM_SX23; b0.imm2 = v[22:0]; return 1;
        end
        if (!split_en) begin
            b0.err = 1'b1; return 1;
        end
        b0.ctrl = IMM_ZX19; b0.imm1 = 19'(v / (2**LO)); b0.hi = 1'b1; b0.last = 1'b0;
        b1.ctrl = IMM_ZX19; b1.imm1 = 19'(v % (2**LO));
        return 2;
    endfunction

    function automatic logic [46:0] pk(input beat_t b);
        return {b.ctrl, b.imm1, b.imm2, b.hi, b.last, b.err};
    endfunction

    // Monitor A
    always @(negedge clk) begin
        beat_t b0, b1, e;
        int n;
        logic [46:0] cur;
        cur = {ia.imm_ctrl, ia.imm_1, ia.imm_2, ia.out_hi, ia.out_last, ia.out_err};
        if (rst) begin
            qa.delete();
            exp_splits_a = 0;
            stall_a = 1'b0;
        end else begin
            if (stall_a) begin
                chk("a_hold_valid", 64'(ia.out_valid), 64'd1);
                chk("a_hold_fields", 64'(cur), 64'(snap_a));
            end
            if (ia.out_valid && ia.out_ready) begin
                if (qa.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_unexpected_beat: got %0h expected none", cur);
                end else begin
                    e = qa.pop_front();
                    chk("a_beat", 64'(cur), 64'(pk(e)));
                end
            end
            if (ia.out_valid && !ia.out_ready) begin
                chk("a_stall_in_ready", 64'(ia.in_ready), 64'd0);
                stall_a = 1'b1;
                snap_a = cur;
            end else begin
                stall_a = 1'b0;
            end
            if (ia.in_valid && ia.in_ready) begin
                n = model(ia.in_value, 1'b1, b0, b1);
                qa.push_back(b0);
                if (n == 2) begin
                    qa.push_back(b1);
                    exp_splits_a++;
                end
            end
        end
    end

    // Monitor B
    always @(negedge clk) begin
        beat_t b0, b1, e;
        int n;
        logic [46:0] cur;
        cur = {ib.imm_ctrl, ib.imm_1, ib.imm_2, ib.out_hi, ib.out_last, ib.out_err};
        if (rst) begin
            qb.delete();
            exp_splits_b = 0;
        end else begin
            if (ib.out_valid && ib.out_ready) begin
                if (qb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_unexpected_beat: got %0h expected none", cur);
                end else begin
                    e = qb.pop_front();
                    chk("b_beat", 64'(cur), 64'(pk(e)));
                end
            end
            if (ib.in_valid && ib.in_ready) begin
                n = model(ib.in_value, 1'b0, b0, b1);
                qb.push_back(b0);
                if (b0.err) exp_splits_b++;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rdy_rand) begin
            ia.out_ready = ($urandom_range(0, 9) < 7);
            ib.out_ready = ($urandom_range(0, 9) < 6);
        end
    end

    // Offer v and return 1 time unit after the accepting edge; in_valid stays up.
    task automatic send(input int d, input logic [31:0] v);
        int t;
        logic rdy;
        t = 0;
        if (d == 0) begin ia.in_valid = 1'b1; ia.in_value = v; end
        else        begin ib.in_valid = 1'b1; ib.in_value = v; end
        do begin
            @(negedge clk);
            rdy = (d == 0) ? ia.in_ready : ib.in_ready;
            t++;
        end while (!rdy && t < 200);
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 within 200 cycles");
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int d);
        if (d == 0) begin ia.in_valid = 1'b0; ia.in_value = $urandom; end
        else        begin ib.in_valid = 1'b0; ib.in_value = $urandom; end
    endtask

    function automatic logic [31:0] rnd_val();
        logic [31:0] bnd [12];
        bnd = '{32'h0007_FFFF, 32'h0008_0000, 32'hFFFC_0000, 32'hFFFB_FFFF,
                32'h003F_FFFF, 32'h0040_0000, 32'hFFC0_0000, 32'hFFBF_FFFF,
                32'h0000_0000, 32'hFFFF_FFFF, 32'h0003_FFFF, 32'h0004_0000};
        case ($urandom_range(0, 4))
            0: return 32'($urandom_range(0, 32'h7FFFF));
            1: return 32'(-int'($urandom_range(1, 262144)));
            2: return 32'($urandom_range(0, 32'h7FFFFF)) - 32'h0040_0000;
            3: return $urandom;
            default: return bnd[$urandom_range(0, 11)];
        endcase
    endfunction

    initial begin
        int t;
        ia.in_valid = 1'b0; ia.in_value = '0; ia.out_ready = 1'b0;
        ib.in_valid = 1'b0; ib.in_value = '0; ib.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(ia.out_valid), 64'd0);
        chk("rst_in_ready", 64'(ia.in_ready), 64'd1);
        chk("rst_ctrl", 64'(ia.imm_ctrl), 64'd3);
        chk("rst_fields", 64'({ia.imm_1, ia.imm_2, ia.out_hi, ia.out_last, ia.out_err}), 64'd0);
        rst = 1'b0;

        // Directed single-beat encodings (contents checked by the scoreboard)
        ia.out_ready = 1'b1;
        send(0, 32'h0004_0000);
        chk("latency_out_valid", 64'(ia.out_valid), 64'd1);
        chk("zx19_imm1", 64'(ia.imm_1), 64'h40000);
        idle(0); @(posedge clk); #1;
        send(0, 32'hFFFF_FFFB);
        chk("sx19_ctrl", 64'(ia.imm_ctrl), 64'd1);
        idle(0); @(posedge clk); #1;
        send(0, 32'hFFF0_0000);
        chk("sx23_imm2", 64'(ia.imm_2), 64'h700000);
        idle(0); @(posedge clk); #1;

        // Split followed by a no-bubble accept on the LO edge
        send(0, 32'h1234_5678);
        ia.in_value = 32'h5;
        @(negedge clk);
        chk("hi_in_ready", 64'(ia.in_ready), 64'd0);
        chk("hi_imm1", 64'(ia.imm_1), 64'h01234);
        @(negedge clk);
        chk("lo_in_ready", 64'(ia.in_ready), 64'd1);
        chk("lo_imm1", 64'(ia.imm_1), 64'h05678);
        @(posedge clk); #1;
        idle(0);
        chk("nobubble_valid", 64'(ia.out_valid), 64'd1);
        chk("nobubble_imm1", 64'(ia.imm_1), 64'h5);
        @(posedge clk); #1;

        // Backpressure held for 3 cycles during HI
        ia.out_ready = 1'b0;
        send(0, 32'h1234_5678);
        ia.in_value = 32'h7;
        repeat (3) begin
            @(negedge clk);
            chk("stall_hi", 64'({ia.out_valid, ia.out_hi, ia.imm_1}), 64'({2'b11, 19'h01234}));
        end
        @(posedge clk); #1;
        ia.out_ready = 1'b1;
        send(0, 32'h7);
        idle(0); @(posedge clk); #1;

        // Reset while in LO
        send(0, 32'h1234_5678);
        idle(0);
        @(posedge clk); #1;
        chk("pre_rst_lo", 64'({ia.out_valid, ia.out_last}), 64'd3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_out_valid", 64'(ia.out_valid), 64'd0);
        chk("midrst_in_ready", 64'(ia.in_ready), 64'd1);
        chk("midrst_ctrl", 64'(ia.imm_ctrl), 64'd3);
        send(0, 32'h5);
        chk("postrst_beat", 64'({ia.imm_ctrl, ia.imm_1}), 64'h5);
        idle(0); @(posedge clk); #1;

        // ALLOW_SPLIT=0 instance
        ib.out_ready = 1'b1;
        send(1, 32'h1234_5678);
        chk("b_err_beat", 64'({ib.imm_ctrl, ib.out_err, ib.out_last, ib.imm_1, ib.imm_2}),
            64'({2'b11, 1'b1, 1'b1, 19'd0, 23'd0}));
        idle(1); @(posedge clk); #1;

        // Randomized traffic with random backpressure
        rdy_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(0, rnd_val());
            if ($urandom_range(0, 3) == 0) begin idle(0); @(posedge clk); #1; end
        end
        idle(0);
        for (int i = 0; i < 150; i++) begin
            send(1, rnd_val());
            if ($urandom_range(0, 3) == 0) begin idle(1); @(posedge clk); #1; end
        end
        idle(1);

        // Drain
        rdy_rand = 1'b0;
        @(posedge clk); #2;
        ia.out_ready = 1'b1;
        ib.out_ready = 1'b1;
        t = 0;
        while ((qa.size() != 0 || qb.size() != 0) && t < 50) begin
            @(posedge clk); t++;
        end
        @(negedge clk);
        chk("a_drain", 64'(qa.size()), 64'd0);
        chk("b_drain", 64'(qb.size()), 64'd0);
        chk("a_idle", 64'({ia.out_valid, ia.in_ready}), 64'd1);
`ifdef IMM_PACK_STATS_EN
        chk("a_split_count", 64'(sc_a), 64'(exp_splits_a));
        chk("b_split_count", 64'(sc_b), 64'(exp_splits_b));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
